// File: rtl/midi_pkg.sv
// Shared MIDI definitions for the transmit and receive paths.
package midi_pkg;

    localparam int unsigned MIDI_BAUD = 31250;

    typedef enum logic [2:0] {
        NOTE_OFF   = 3'd0,
        NOTE_ON    = 3'd1,
        POLY_AT    = 3'd2,
        CTRL_CHG   = 3'd3,
        PROG_CHG   = 3'd4,
        CHAN_AT    = 3'd5,
        PITCH_BEND = 3'd6,
        SYSTEM     = 3'd7
    } midi_msg_t;

    // One latched channel message awaiting serialisation.
    typedef struct packed {
        logic [7:0] status;
        logic [6:0] data1;
        logic [6:0] data2;
        logic       three;
    } midi_frame_t;

    // Total bytes in a channel message including the status byte.
    function automatic logic [1:0] midi_msg_len(input midi_msg_t t);
        return ((t == PROG_CHG) || (t == CHAN_AT)) ? 2'd2 : 2'd3;
    endfunction

endpackage

// File: rtl/uart_transmit.sv
// UART 8N1 byte transmitter; one load cycle, then start, 8 data bits LSB first, stop.
module uart_transmit #(
    parameter int unsigned INPUT_CLOCK_FREQ = 100_000_000,
    parameter int unsigned BAUD_RATE        = 31250
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [7:0] data_byte_in,
    input  logic       trigger_in,
    output logic       busy_out,
    output logic       done_out,
    output logic       tx_wire_out
);

    localparam int unsigned BAUD_PERIOD = INPUT_CLOCK_FREQ / BAUD_RATE;
    localparam int unsigned CNT_W       = (BAUD_PERIOD > 1) ? $clog2(BAUD_PERIOD) : 1;
    localparam int unsigned LAST_BIT    = 9;

    logic [CNT_W-1:0] baud_cnt;
    logic [3:0]       bit_cnt;
    logic [8:0]       shift;
    logic             loading;
    logic             active;
    logic             baud_end;
    logic             stop_bit;

    assign baud_end = (baud_cnt == CNT_W'(BAUD_PERIOD - 1));
    assign stop_bit = (bit_cnt == 4'(LAST_BIT));

    // busy/done drop one cycle before the stop bit ends so a follow-on byte can load seamlessly.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            busy_out    <= 1'b0;
            done_out    <= 1'b0;
            tx_wire_out <= 1'b1;
            loading     <= 1'b0;
            active      <= 1'b0;
            baud_cnt    <= '0;
            bit_cnt     <= '0;
            shift       <= '0;
        end else begin
            done_out <= 1'b0;
            if (trigger_in && !busy_out) begin
                busy_out <= 1'b1;
                loading  <= 1'b1;
                active   <= 1'b0;
                shift    <= {1'b1, data_byte_in};
            end else if (loading) begin
                loading     <= 1'b0;
                active      <= 1'b1;
                tx_wire_out <= 1'b0;
                baud_cnt    <= '0;
                bit_cnt     <= '0;
            end else if (active) begin
                if (baud_end) begin
                    baud_cnt <= '0;
                    if (stop_bit) begin
                        active <= 1'b0;
                    end else begin
                        bit_cnt     <= bit_cnt + 4'd1;
                        tx_wire_out <= shift[0];
                        shift       <= {1'b0, shift[8:1]};
                    end
                end else begin
                    baud_cnt <= baud_cnt + CNT_W'(1);
                end
                if (stop_bit && (baud_cnt == CNT_W'(BAUD_PERIOD - 2))) begin
                    busy_out <= 1'b0;
                    done_out <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/midi_writer.sv
// MIDI OUT channel-message transmitter: frames status + data bytes onto a 31250 baud UART.
module midi_writer
    import midi_pkg::*;
#(
    parameter int unsigned INPUT_CLOCK_FREQ = 100_000_000,
    parameter int unsigned BAUD_RATE        = MIDI_BAUD,
    parameter bit          RUNNING_STATUS   = 1'b0
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [2:0] msg_type_in,
    input  logic [3:0] channel_in,
    input  logic [6:0] data_byte1_in,
    input  logic [6:0] data_byte2_in,
    input  logic       valid_in,
    output logic       ready_out,
    output logic       drop_out,
    output logic       tx_wire_out
);

    typedef enum logic [1:0] {IDLE, SEND_STATUS, SEND_BYTE1, SEND_BYTE2} state_t;

    state_t      state, state_n, target_c;
    midi_frame_t msg;
    logic [7:0]  last_status;
    logic [7:0]  status_in_c;
    logic [7:0]  byte_c;
    logic        issued, issued_n;
    logic        ready_n, drop_n;
    logic        trigger_c;
    logic        accept_c;
    logic        uart_busy, uart_done;

    assign status_in_c = {1'b1, msg_type_in, channel_in};
    assign accept_c    = valid_in && ready_out;

    // Next state; on a done pulse the following byte is triggered in the same cycle.
    always_comb begin
        state_n   = state;
        target_c  = state;
        issued_n  = issued;
        ready_n   = ready_out;
        drop_n    = 1'b0;
        trigger_c = 1'b0;
        case (state)
            IDLE: begin
                if (accept_c) begin
                    if (midi_msg_t'(msg_type_in) == SYSTEM) begin
                        drop_n = 1'b1;
                    end else begin
                        ready_n  = 1'b0;
                        issued_n = 1'b0;
                        state_n  = (RUNNING_STATUS && (status_in_c == last_status))
                                   ? SEND_BYTE1 : SEND_STATUS;
                    end
                end
            end
            default: begin
                if (uart_done) begin
                    issued_n = 1'b0;
                    case (state)
                        SEND_STATUS: state_n = SEND_BYTE1;
                        SEND_BYTE1:  state_n = msg.three ? SEND_BYTE2 : IDLE;
                        default:     state_n = IDLE;
                    endcase
                    if (state_n == IDLE) begin
                        ready_n = 1'b1;
                    end else begin
                        trigger_c = 1'b1;
                        issued_n  = 1'b1;
                        target_c  = state_n;
                    end
                end else if (!issued && !uart_busy) begin
                    trigger_c = 1'b1;
                    issued_n  = 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        case (target_c)
            SEND_STATUS: byte_c = msg.status;
            SEND_BYTE1:  byte_c = {1'b0, msg.data1};
            default:     byte_c = {1'b0, msg.data2};
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state       <= IDLE;
            issued      <= 1'b0;
            ready_out   <= 1'b1;
            drop_out    <= 1'b0;
            last_status <= 8'h00;
            msg         <= '0;
        end else begin
            state     <= state_n;
            issued    <= issued_n;
            ready_out <= ready_n;
            drop_out  <= drop_n;
            if (accept_c && (state == IDLE)) begin
                msg <= '{status: status_in_c,
                         data1:  data_byte1_in,
                         data2:  data_byte2_in,
                         three:  (midi_msg_len(midi_msg_t'(msg_type_in)) == 2'd3)};
            end
            if (trigger_c && (target_c == SEND_STATUS)) begin
                last_status <= byte_c;
            end
        end
    end

    uart_transmit #(
        .INPUT_CLOCK_FREQ(INPUT_CLOCK_FREQ),
        .BAUD_RATE       (BAUD_RATE)
    ) u_uart (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .data_byte_in(byte_c),
        .trigger_in  (trigger_c),
        .busy_out    (uart_busy),
        .done_out    (uart_done),
        .tx_wire_out (tx_wire_out)
    );

endmodule

// File: tb/tb_midi_writer.sv
// Directed bench for midi_writer: mid-bit UART sampler feeding a byte scoreboard.
module tb_midi_writer;
    import midi_pkg::*;

    localparam int unsigned CLK_HZ = 2_000_000;
    localparam int          P      = CLK_HZ / MIDI_BAUD;
    localparam int          LIMIT  = 40 * P;
    localparam bit          RS     = 1'b1;

    logic       clk_in = 1'b0;
    logic       rst_in = 1'b1;
    logic [2:0] msg_type_in = '0;
    logic [3:0] channel_in = '0;
    logic [6:0] data_byte1_in = '0;
    logic [6:0] data_byte2_in = '0;
    logic       valid_in = 1'b0;
    logic       ready_out, drop_out, tx_wire_out;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] model_last = 8'h00;

    logic       mon_active = 1'b0;
    int         mon_cnt = 0;
    logic [7:0] mon_byte = '0;

    always #5 clk_in = ~clk_in;

    midi_writer #(
        .INPUT_CLOCK_FREQ(CLK_HZ),
        .BAUD_RATE       (MIDI_BAUD),
        .RUNNING_STATUS  (RS)
    ) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .msg_type_in  (msg_type_in),
        .channel_in   (channel_in),
        .data_byte1_in(data_byte1_in),
        .data_byte2_in(data_byte2_in),
        .valid_in     (valid_in),
        .ready_out    (ready_out),
        .drop_out     (drop_out),
        .tx_wire_out  (tx_wire_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
        checks++;
        assert (obs >= lo && obs <= hi) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    // Mid-bit sampler; a reset abandons the frame in flight.
    always @(negedge clk_in) begin
        if (rst_in) begin
            mon_active = 1'b0;
        end else if (!mon_active) begin
            if (tx_wire_out === 1'b0) begin
                mon_active = 1'b1;
                mon_cnt    = 0;
            end
        end else begin
            mon_cnt++;
            if (mon_cnt == P / 2) begin
                chk("start_bit", tx_wire_out, 1'b0);
            end else if (mon_cnt > P / 2 && ((mon_cnt - P / 2) % P) == 0) begin
                if ((mon_cnt - P / 2) / P <= 8) begin
                    mon_byte = {tx_wire_out, mon_byte[7:1]};
                end else begin
                    chk("stop_bit", tx_wire_out, 1'b1);
                    chk("rx_byte_expected", 32'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) chk("rx_byte", mon_byte, exp_q.pop_front());
                    mon_active = 1'b0;
                end
            end
        end
    end

    task automatic drive(input logic [2:0] t, input logic [3:0] ch,
                         input logic [6:0] d1, input logic [6:0] d2);
        msg_type_in   = t;
        channel_in    = ch;
        data_byte1_in = d1;
        data_byte2_in = d2;
    endtask

    // Reference framing: status (unless repeated), data1, data2 for 3-byte types.
    task automatic push_msg(input logic [2:0] t, input logic [3:0] ch,
                            input logic [6:0] d1, input logic [6:0] d2);
        logic [7:0] st;
        if (t == 3'd7) return;
        st = {1'b1, t, ch};
        if (!(RS && st == model_last)) exp_q.push_back(st);
        model_last = st;
        exp_q.push_back({1'b0, d1});
        if (t != 3'd4 && t != 3'd5) exp_q.push_back({1'b0, d2});
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        @(negedge clk_in);
        while (ready_out !== 1'b1 && n < LIMIT) begin
            @(negedge clk_in);
            n++;
        end
        chk({tag, "_ready"}, ready_out, 1'b1);
    endtask

    // Returns at accept edge + 1.
    task automatic send(input string tag, input logic [2:0] t, input logic [3:0] ch,
                        input logic [6:0] d1, input logic [6:0] d2, input bit push_en);
        wait_ready(tag);
        drive(t, ch, d1, d2);
        valid_in = 1'b1;
        if (push_en) push_msg(t, ch, d1, d2);
        @(posedge clk_in);
        #1 valid_in = 1'b0;
    endtask

    task automatic measure(input string tag, input int lo, input int hi);
        int n = 0;
        int fall = -1;
        while (ready_out !== 1'b1 && n < LIMIT) begin
            @(posedge clk_in);
            #1;
            n++;
            if (fall < 0 && tx_wire_out === 1'b0) fall = n;
        end
        chk_rng({tag, "_ready_low"}, n, lo, hi);
        chk({tag, "_tx_fall_edge"}, fall, 2);
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while ((ready_out !== 1'b1 || mon_active || exp_q.size() != 0) && n < LIMIT) begin
            @(negedge clk_in);
            n++;
        end
        chk({tag, "_drained"}, exp_q.size(), 0);
    endtask

    initial begin
        #20000000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk_in);
        #1;
        chk("reset_ready", ready_out, 1'b1);
        chk("reset_drop", drop_out, 1'b0);
        chk("reset_tx", tx_wire_out, 1'b1);
        @(negedge clk_in) rst_in = 1'b0;

        // NoteOn ch0
        send("t1", 3'd1, 4'd0, 7'h3C, 7'h64, 1'b1);
        measure("t1", 30 * P - 4, 30 * P + 4);
        wait_drain("t1");

        // ProgChg ch9: second data byte must never appear
        send("t2", 3'd4, 4'd9, 7'h05, 7'h7F, 1'b1);
        measure("t2", 20 * P, 20 * P + 3);
        wait_drain("t2");

        // Running status: repeated NoteOn ch2 omits status, CC ch2 resends it
        send("t3a", 3'd1, 4'd2, 7'h40, 7'h50, 1'b1);
        wait_drain("t3a");
        send("t3b", 3'd1, 4'd2, 7'h43, 7'h50, 1'b1);
        measure("t3b", 20 * P, 20 * P + 3);
        wait_drain("t3b");
        send("t3c", 3'd3, 4'd2, 7'h07, 7'h7F, 1'b1);
        wait_drain("t3c");

        // System message is dropped and leaves last status untouched
        send("t4", 3'd7, 4'd2, 7'h11, 7'h22, 1'b1);
        chk("t4_drop_pulse", drop_out, 1'b1);
        chk("t4_ready", ready_out, 1'b1);
        chk("t4_tx_idle", tx_wire_out, 1'b1);
        @(posedge clk_in);
        #1;
        chk("t4_drop_end", drop_out, 1'b0);
        chk("t4_tx_still_idle", tx_wire_out, 1'b1);
        send("t4b", 3'd3, 4'd2, 7'h03, 7'h04, 1'b1);
        wait_drain("t4b");

        // valid held high with churning inputs while busy
        wait_ready("t5a");
        drive(3'd2, 4'd5, 7'h11, 7'h22);
        valid_in = 1'b1;
        push_msg(3'd2, 4'd5, 7'h11, 7'h22);
        @(posedge clk_in);
        for (int n = 0; n < LIMIT; n++) begin
            @(negedge clk_in);
            if (ready_out === 1'b1) break;
            drive(3'($urandom_range(0, 7)), 4'($urandom), 7'($urandom), 7'($urandom));
        end
        chk("t5_ready_back", ready_out, 1'b1);
        drive(3'd5, 4'd3, 7'h33, 7'h44);
        push_msg(3'd5, 4'd3, 7'h33, 7'h44);
        @(posedge clk_in);
        #1 valid_in = 1'b0;
        wait_drain("t5");

        // Reset mid-byte of 0x90, then the same NoteOn must resend its status
        send("t6a", 3'd1, 4'd0, 7'h3C, 7'h64, 1'b0);
        repeat (3 * P + 8) @(posedge clk_in);
        @(negedge clk_in);
        chk("t6_tx_low_before_reset", tx_wire_out, 1'b0);
        rst_in = 1'b1;
        @(posedge clk_in);
        #1;
        chk("t6_tx_after_reset", tx_wire_out, 1'b1);
        chk("t6_ready_after_reset", ready_out, 1'b1);
        model_last = 8'h00;
        @(negedge clk_in) rst_in = 1'b0;
        send("t6b", 3'd1, 4'd0, 7'h3C, 7'h64, 1'b1);
        wait_drain("t6b");

        chk("final_queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
